// File: rtl/add_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package add_serial_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Legal only for WIDTH >= 2 with DIGIT a non-zero divisor of WIDTH.
  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit != 0) && (digit <= width) && ((width % digit) == 0);
  endfunction

  function automatic int unsigned count_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_fa.sv
// DIGIT-bit ripple-carry full adder; also exposes the carry into its top bit.
module serial_digit_fa #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor with valid/ready on both sides and carry/overflow flags.
// Optional saturation on signed overflow when ADD_SERIAL_SAT_EN is defined.
module add_serial_param
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("add_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  localparam int unsigned BEATS = WIDTH / DIGIT;
  localparam int unsigned CW    = count_width(BEATS);
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic [DIGIT-1:0]       fa_s;
  logic                   fa_cout;
  logic                   fa_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  serial_digit_fa #(
    .DIGIT(DIGIT)
  ) u_fa (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout),
    .c_msb(fa_cmsb)
  );

  // New digit enters from the MSB side; after BEATS shifts the LSB digit is at the bottom.
  assign sum_cat = {fa_s, sum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    co_d    = co_q;
    ov_d    = ov_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          sum_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = fa_cout;
        count_d = count_q + CW'(1);
        if (count_q == LastBeat) begin
          co_d    = fa_cout;
          ov_d    = fa_cmsb ^ fa_cout;
          state_d = StDone;
`ifdef ADD_SERIAL_SAT_EN
          // a_q now holds only the top digit of A, so its MSB is A's sign.
          if (fa_cmsb ^ fa_cout) begin
            sum_d = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule
